// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register indices FIRST_REG..LAST_REG through one
// register-file read port and streams each value out on a valid/ready
// interface, tagged with its index, while accumulating a wrapping checksum.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            begin a dump (honoured only while idle)
//   abort            cancel an in-progress dump (fetch or send phase)
//   rd_addr/rd_data  register-file read port (combinational read data)
//   dump_valid/ready handshake for dump_data/dump_index
//   busy             high whenever not idle
//   done             one-cycle pulse after the last word is accepted
//   checksum         mod-2^32 sum of accepted words
module reg_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [4:0]  dump_index,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  idx;
  logic        accept;

  // A word counts only on a handshake that is not pre-empted by abort.
  always_comb begin
    accept     = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (abort) state_next = IDLE;
        else       state_next = SEND;
      end
      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (dump_valid && dump_ready) begin
          accept     = 1'b1;
          state_next = (idx == LAST_IDX) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= FIRST_IDX;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_index <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= FIRST_IDX;
            checksum <= '0;
          end
        end
        FETCH: begin
          if (abort) begin
            dump_valid <= 1'b0;
          end else begin
            dump_data  <= rd_data;
            dump_index <= idx;
            dump_valid <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            dump_valid <= 1'b0;
          end else if (accept) begin
            checksum   <= checksum + dump_data;
            dump_valid <= 1'b0;
            if (idx != LAST_IDX) idx <= idx + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_addr = idx;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Sequential read-back engine for the MIPS register file. On a start pulse it walks a contiguous range of register indices through one register-file read port and streams each 32-bit value out over a valid/ready interface, tagged with its index. It also accumulates a wrapping checksum. It sits beside the register block as a debug and verification path that reads register state, replacing file-based inspection.

Parameters:
FIRST_REG, 0, first register index dumped (0..31)
LAST_REG, 31, last register index dumped (FIRST_REG..31)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a dump; honoured only in IDLE
abort  input  1  cancel an in-progress dump
rd_addr  output  5  read-register index driven to a register-file read port
rd_data  input  32  combinational read data returned for rd_addr
dump_valid  output  1  dump_data/dump_index hold a valid word
dump_ready  input  1  consumer accepts the word when dump_valid & dump_ready
dump_data  output  32  register value
dump_index  output  5  register index of dump_data
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word is accepted
checksum  output  32  wrapping sum of accepted words, stable from done until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idx=FIRST_REG; rd_addr=FIRST_REG; dump_valid=0; dump_data=0; dump_index=0; busy=0; done=0; checksum=0.
- States: IDLE, FETCH, SEND, DONE.
- IDLE: rd_addr=idx. If start=1, set idx=FIRST_REG, clear checksum to 0, go to FETCH. start in any other state is ignored.
- FETCH (1 cycle): rd_addr=idx. At the clock edge, capture dump_data<=rd_data and dump_index<=idx, set dump_valid<=1, go to SEND.
- SEND: dump_data and dump_index are held stable while dump_valid=1 and dump_ready=0. On a handshake, add dump_data to checksum (mod 2^32) and clear dump_valid.
  - If idx==LAST_REG, go to DONE.
  - Otherwise increment idx and go to FETCH.
- DONE: done=1 for exactly this cycle, then go to IDLE. checksum keeps its value until the next accepted start.
- Throughput is one word per 2 cycles minimum. Latency from start to first dump_valid is 2 cycles.
- Index count: LAST_REG-FIRST_REG+1 words. idx never wraps past 31. With FIRST_REG==LAST_REG, exactly one word is sent.
- abort=1 in FETCH or SEND: next state is IDLE, dump_valid<=0, and no done pulse occurs. abort has priority over a simultaneous handshake; that word is not counted in checksum. checksum then holds the partial sum. abort in IDLE or DONE has no effect, and done still pulses.
- start and abort asserted together in IDLE: start wins.
- rd_data is sampled only in FETCH. Register-file writes landing in the same cycle follow the register file's read-before-write timing; the value sampled is whatever rd_data shows pre-edge.
- Reset mid-dump: immediate return to reset values, no done.
- dump_valid never drops without a handshake, except on abort or reset.

Test Plan:
- Default params; register file preloaded with reg[i]=i*0x11111111 mod 2^32; start pulse; dump_ready held at 1 -> 32 words, index 0..31, data matches, first dump_valid 2 cycles after start, done at cycle 65, checksum = sum mod 2^32.
- Random dump_ready backpressure (~50%) -> dump_data/dump_index stable while stalled, no loss or duplication, same checksum as the previous test.
- FIRST_REG=26, LAST_REG=26; reg[26]=0xDEADBEEF -> single word at index 26; done pulses; checksum=0xDEADBEEF.
- Abort asserted in SEND of index 5 together with dump_ready=1 -> dump_valid=0 next cycle, no done, checksum = sum of reg[0..4], busy=0.
- start pulses repeated during an active dump -> ignored; the dump completes normally with 32 words.
- rst_n asserted asynchronously mid-SEND (between clock edges) -> outputs go to reset values immediately. A new start afterwards produces a full, correct dump.
